// File: rtl/mem_stage_pkg.sv
// Shared widths, load-op encodings and bus layouts for the MEM pipeline stage.
package mem_stage_pkg;

    localparam int EXEReg_BUS_LEN = 92;
    localparam int MEMReg_BUS_LEN = 87;
    localparam int BYPASS_BUS_LEN = 40;
    localparam int EBUS_W         = 16;

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;

    // Bit positions of exception flags within ebus
    localparam int EBUS_INT  = 0;
    localparam int EBUS_ADEF = 1;
    localparam int EBUS_ALE  = 2;
    localparam int EBUS_SYS  = 3;
    localparam int EBUS_BRK  = 4;
    localparam int EBUS_INE  = 5;

    typedef struct packed {
        logic              ertn;
        logic [EBUS_W-1:0] ebus;
        logic              mem_req;
        logic [2:0]        ld_op;
        logic              res_from_mem;
        logic              rf_we;
        logic [4:0]        rf_waddr;
        logic [31:0]       alu_result;
        logic [31:0]       pc;
    } exe_bus_t;

    typedef struct packed {
        logic              ertn;
        logic [EBUS_W-1:0] ebus;
        logic [31:0]       final_result;
        logic              rf_we;
        logic [4:0]        rf_waddr;
        logic [31:0]       pc;
    } mem_bus_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte/halfword of a load response and sign/zero-extends it.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  ld_op,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (off)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
    end

    assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    // Unknown encodings fall back to a full word
    always_comb begin
        result = rdata;
        case (ld_op)
            LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   result = {24'd0, byte_sel};
            LD_H:    result = {{16{half_sel[15]}}, half_sel};
            LD_HU:   result = {16'd0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds the MEM register, waits for data-SRAM responses,
// formats load data and owns the MEM->WB register; drops stale responses after flush.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int CANCEL_W = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      exe_valid,
    input  logic                      EXE_ready_go,
    input  logic [EXEReg_BUS_LEN-1:0] EXEreg_bus,
    output logic                      MEM_allow_in,
    output logic                      MEM_ready_go,
    input  logic                      data_sram_data_ok,
    input  logic [31:0]               data_sram_rdata,
    input  logic                      flush,
    input  logic                      WB_allow_in,
    output logic                      wb_valid,
    output logic [MEMReg_BUS_LEN-1:0] MEMreg_bus,
    output logic [BYPASS_BUS_LEN-1:0] MEM_bypass_bus
);

    localparam logic [CANCEL_W-1:0] CANCEL_MAX = '1;
    localparam logic [CANCEL_W-1:0] CANCEL_ONE = CANCEL_W'(1);

    exe_bus_t            exe_in;
    exe_bus_t            mem_r;
    mem_bus_t            wb_next;
    logic                mem_valid;
    logic                got_data;
    logic [31:0]         rdata_buf;
    logic [CANCEL_W-1:0] cancel_cnt;

    logic        data_ok_live;
    logic        need_data;
    logic        capture;
    logic        advance;
    logic        cancel_inc;
    logic        cancel_dec;
    logic        load_pending;
    logic [31:0] rdata_sel;
    logic [31:0] formatted;
    logic [31:0] final_result;

    assign exe_in = exe_bus_t'(EXEreg_bus);

    // Responses owed to flushed instructions are swallowed while cancel_cnt is nonzero
    assign data_ok_live = data_sram_data_ok & (cancel_cnt == '0);
    assign need_data    = mem_valid & mem_r.mem_req & ~got_data;
    assign MEM_ready_go = ~need_data | data_ok_live;
    assign MEM_allow_in = ~mem_valid | (MEM_ready_go & WB_allow_in);
    assign capture      = exe_valid & EXE_ready_go & MEM_allow_in;
    assign advance      = mem_valid & MEM_ready_go & WB_allow_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid <= 1'b0;
        end else if (flush) begin
            mem_valid <= 1'b0;
        end else if (MEM_allow_in) begin
            mem_valid <= exe_valid & EXE_ready_go;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_r <= '0;
        end else if (capture) begin
            mem_r <= exe_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            got_data  <= 1'b0;
            rdata_buf <= 32'd0;
        end else if (flush || advance) begin
            got_data  <= 1'b0;
        end else if (need_data && data_ok_live && !WB_allow_in) begin
            got_data  <= 1'b1;
            rdata_buf <= data_sram_rdata;
        end
    end

    // A response arriving in the flush cycle itself settles the outstanding request
    assign cancel_inc = flush & need_data & ~data_ok_live;
    assign cancel_dec = data_sram_data_ok & (cancel_cnt != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cancel_cnt <= '0;
        end else if (cancel_inc && !cancel_dec) begin
            if (cancel_cnt != CANCEL_MAX) begin
                cancel_cnt <= cancel_cnt + CANCEL_ONE;
            end
        end else if (cancel_dec && !cancel_inc) begin
            cancel_cnt <= cancel_cnt - CANCEL_ONE;
        end
    end

    assign rdata_sel = got_data ? rdata_buf : data_sram_rdata;

    load_align u_load_align (
        .ld_op  (mem_r.ld_op),
        .off    (mem_r.alu_result[1:0]),
        .rdata  (rdata_sel),
        .result (formatted)
    );

    assign final_result = mem_r.res_from_mem ? formatted : mem_r.alu_result;
    assign load_pending = mem_r.res_from_mem & ~MEM_ready_go;

    assign MEM_bypass_bus = {mem_valid, load_pending, mem_r.rf_we, mem_r.rf_waddr, final_result};

    always_comb begin
        wb_next              = '0;
        wb_next.ertn         = mem_r.ertn;
        wb_next.ebus         = mem_r.ebus;
        wb_next.final_result = final_result;
        wb_next.rf_we        = mem_r.rf_we;
        wb_next.rf_waddr     = mem_r.rf_waddr;
        wb_next.pc           = mem_r.pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid   <= 1'b0;
            MEMreg_bus <= '0;
        end else begin
            if (flush) begin
                wb_valid <= 1'b0;
            end else if (WB_allow_in) begin
                wb_valid <= mem_valid & MEM_ready_go;
            end
            if (WB_allow_in) begin
                MEMreg_bus <= wb_next;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, randomized transactions
// against a reference load model, and hand-written flush/reset sequences.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        exe_valid;
    logic        EXE_ready_go;
    logic [91:0] EXEreg_bus;
    logic        MEM_allow_in;
    logic        MEM_ready_go;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        flush;
    logic        WB_allow_in;
    logic        wb_valid;
    logic [86:0] MEMreg_bus;
    logic [39:0] MEM_bypass_bus;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage #(.CANCEL_W(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .exe_valid         (exe_valid),
        .EXE_ready_go      (EXE_ready_go),
        .EXEreg_bus        (EXEreg_bus),
        .MEM_allow_in      (MEM_allow_in),
        .MEM_ready_go      (MEM_ready_go),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .flush             (flush),
        .WB_allow_in       (WB_allow_in),
        .wb_valid          (wb_valid),
        .MEMreg_bus        (MEMreg_bus),
        .MEM_bypass_bus    (MEM_bypass_bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic        rfm;
        logic        mreq;
        logic [31:0] alu;
        logic [31:0] rdata;
        int          wait_n;
        int          bp_n;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [91:0] mk_exe(input logic ertn, input logic [15:0] ebus,
                                           input logic mreq, input logic [2:0] op,
                                           input logic rfm, input logic we,
                                           input logic [4:0] wa, input logic [31:0] alu,
                                           input logic [31:0] pc);
        return {ertn, ebus, mreq, op, rfm, we, wa, alu, pc};
    endfunction

    // Reference: shift the word down to the addressed unit, then extend arithmetically
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int unsigned off;
        logic [31:0] w;
        longint      v;
        off = int'(addr % 4);
        case (op)
            3'd1, 3'd2: begin
                w = rdata >> (8 * off);
                v = longint'(w & 32'hFF);
                if (op == 3'd1 && v >= 128) v = v - 256;
            end
            3'd3, 3'd4: begin
                w = rdata >> (16 * (off / 2));
                v = longint'(w & 32'hFFFF);
                if (op == 3'd3 && v >= 32768) v = v - 65536;
            end
            default: v = longint'(rdata);
        endcase
        return 32'(v);
    endfunction

    task automatic run_txn(input logic [91:0] bus, input logic mreq, input logic rfm,
                           input logic [31:0] rdata, input int wait_n, input int bp_n,
                           input logic [86:0] exp_bus);
        exe_valid    = 1'b1;
        EXE_ready_go = 1'b1;
        EXEreg_bus   = bus;
        WB_allow_in  = 1'b1;
        #1;
        chk("allow_in_at_issue", 128'(MEM_allow_in), 128'(1'b1));
        step();
        exe_valid = 1'b0;
        if (mreq) begin
            for (int i = 0; i < wait_n; i++) begin
                data_sram_data_ok = 1'b0;
                data_sram_rdata   = $urandom;
                #1;
                chk("ready_go_waiting", 128'(MEM_ready_go), 128'(1'b0));
                chk("load_pending", 128'(MEM_bypass_bus[38]), 128'(rfm));
                step();
            end
        end
        data_sram_data_ok = mreq;
        data_sram_rdata   = rdata;
        WB_allow_in       = (bp_n == 0);
        #1;
        chk("ready_go_done", 128'(MEM_ready_go), 128'(1'b1));
        chk("fwd_data", 128'(MEM_bypass_bus[31:0]), 128'(exp_bus[69:38]));
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = $urandom;
        if (bp_n > 0) begin
            for (int i = 1; i < bp_n; i++) begin
                #1;
                chk("ready_go_stalled", 128'(MEM_ready_go), 128'(1'b1));
                step();
            end
            WB_allow_in = 1'b1;
            #1;
            chk("ready_go_release", 128'(MEM_ready_go), 128'(1'b1));
            chk("fwd_data_buffered", 128'(MEM_bypass_bus[31:0]), 128'(exp_bus[69:38]));
            step();
        end
        chk("wb_valid", 128'(wb_valid), 128'(1'b1));
        chk("MEMreg_bus", 128'(MEMreg_bus), 128'(exp_bus));
    endtask

    task automatic issue(input logic [91:0] bus);
        exe_valid    = 1'b1;
        EXE_ready_go = 1'b1;
        EXEreg_bus   = bus;
        step();
        exe_valid = 1'b0;
    endtask

    initial begin
        logic [91:0] bus;
        logic [86:0] eb;
        logic [2:0]  op;
        logic        rfm;
        logic        mreq;
        logic        we;
        logic        ertn;
        logic [15:0] ebus;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [31:0] pc;
        logic [31:0] fin;
        logic [4:0]  wa;

        vecs[0] = '{3'd0, 1'b0, 1'b0, 32'h0000_0005, 32'h0,          0, 0, 32'h0000_0005};
        vecs[1] = '{3'd1, 1'b1, 1'b1, 32'h0000_1002, 32'h1280_3456, 3, 0, 32'hFFFF_FF80};
        vecs[2] = '{3'd2, 1'b1, 1'b1, 32'h0000_1002, 32'h1280_3456, 3, 0, 32'h0000_0080};
        vecs[3] = '{3'd4, 1'b1, 1'b1, 32'h0000_2002, 32'h8001_0000, 1, 0, 32'h0000_8001};
        vecs[4] = '{3'd3, 1'b1, 1'b1, 32'h0000_2002, 32'h8001_0000, 1, 0, 32'hFFFF_8001};
        vecs[5] = '{3'd0, 1'b1, 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 0, 2, 32'hCAFE_F00D};
        vecs[6] = '{3'd1, 1'b1, 1'b1, 32'h0000_0303, 32'h7F00_0000, 0, 1, 32'h0000_007F};
        vecs[7] = '{3'd0, 1'b0, 1'b1, 32'h0000_2000, 32'h5555_AAAA, 2, 0, 32'h0000_2000};
        vecs[8] = '{3'd6, 1'b1, 1'b1, 32'h0000_0041, 32'h89AB_CDEF, 1, 0, 32'h89AB_CDEF};

        reset             = 1'b1;
        exe_valid         = 1'b0;
        EXE_ready_go      = 1'b0;
        EXEreg_bus        = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        flush             = 1'b0;
        WB_allow_in       = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("reset_allow_in", 128'(MEM_allow_in), 128'(1'b1));
        chk("reset_ready_go", 128'(MEM_ready_go), 128'(1'b1));
        chk("reset_wb_valid", 128'(wb_valid), 128'(1'b0));
        chk("reset_MEMreg_bus", 128'(MEMreg_bus), 128'(0));
        chk("reset_bypass", 128'(MEM_bypass_bus), 128'(0));

        for (int i = 0; i < 9; i++) begin
            we  = ~(vecs[i].mreq & ~vecs[i].rfm);
            wa  = 5'(i + 3);
            pc  = 32'h1c00_0000 + 32'(i * 4);
            bus = mk_exe(1'b0, 16'h0, vecs[i].mreq, vecs[i].op, vecs[i].rfm, we, wa,
                         vecs[i].alu, pc);
            eb  = {1'b0, 16'h0, vecs[i].exp, we, wa, pc};
            run_txn(bus, vecs[i].mreq, vecs[i].rfm, vecs[i].rdata,
                    vecs[i].wait_n, vecs[i].bp_n, eb);
        end

        for (int i = 0; i < 40; i++) begin
            op   = 3'($urandom_range(0, 7));
            rfm  = 1'($urandom);
            mreq = rfm | 1'($urandom);
            we   = ~(mreq & ~rfm);
            ertn = mreq ? 1'b0 : 1'($urandom);
            ebus = mreq ? 16'h0 : 16'($urandom);
            alu  = $urandom;
            rd   = $urandom;
            pc   = $urandom & 32'hFFFF_FFFC;
            wa   = 5'($urandom);
            fin  = rfm ? ref_load(op, alu, rd) : alu;
            bus  = mk_exe(ertn, ebus, mreq, op, rfm, we, wa, alu, pc);
            eb   = {ertn, ebus, fin, we, wa, pc};
            run_txn(bus, mreq, rfm, rd, $urandom_range(0, 3), $urandom_range(0, 2), eb);
        end

        // Flush with an outstanding load: its late response must be discarded
        WB_allow_in = 1'b1;
        issue(mk_exe(1'b0, 16'h0, 1'b1, 3'd0, 1'b1, 1'b1, 5'd7, 32'h0000_0080, 32'h1c00_1000));
        flush = 1'b1;
        #1;
        chk("flush_need_data", 128'(MEM_ready_go), 128'(1'b0));
        step();
        flush = 1'b0;
        chk("flush_cancel_cnt", 128'(dut.cancel_cnt), 128'(1));
        chk("flush_mem_valid", 128'(MEM_bypass_bus[39]), 128'(1'b0));
        chk("flush_wb_valid", 128'(wb_valid), 128'(1'b0));
        issue(mk_exe(1'b0, 16'h0, 1'b1, 3'd0, 1'b1, 1'b1, 5'd8, 32'h0000_0040, 32'h1c00_1004));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        #1;
        chk("stale_ready_go", 128'(MEM_ready_go), 128'(1'b0));
        step();
        chk("stale_cancel_cnt", 128'(dut.cancel_cnt), 128'(0));
        chk("stale_wb_valid", 128'(wb_valid), 128'(1'b0));
        data_sram_rdata = 32'h1357_9BDF;
        #1;
        chk("live_ready_go", 128'(MEM_ready_go), 128'(1'b1));
        step();
        data_sram_data_ok = 1'b0;
        chk("post_flush_wb_valid", 128'(wb_valid), 128'(1'b1));
        chk("post_flush_result", 128'(MEMreg_bus),
            128'({1'b0, 16'h0, 32'h1357_9BDF, 1'b1, 5'd8, 32'h1c00_1004}));
        step();
        chk("post_flush_wb_once", 128'(wb_valid), 128'(1'b0));

        // Flush racing data_ok: response belongs to the flushed load
        issue(mk_exe(1'b0, 16'h0, 1'b1, 3'd0, 1'b1, 1'b1, 5'd9, 32'h0000_0010, 32'h1c00_2000));
        flush             = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0BAD_0BAD;
        step();
        flush             = 1'b0;
        data_sram_data_ok = 1'b0;
        chk("race_cancel_cnt", 128'(dut.cancel_cnt), 128'(0));
        chk("race_wb_valid", 128'(wb_valid), 128'(1'b0));
        chk("race_mem_valid", 128'(MEM_bypass_bus[39]), 128'(1'b0));

        // Flush in the handover cycle drops the incoming instruction
        exe_valid    = 1'b1;
        EXE_ready_go = 1'b1;
        EXEreg_bus   = mk_exe(1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b1, 5'd4, 32'h77, 32'h1c00_3000);
        flush        = 1'b1;
        step();
        exe_valid = 1'b0;
        flush     = 1'b0;
        chk("handover_flush_mem_valid", 128'(MEM_bypass_bus[39]), 128'(1'b0));
        chk("handover_flush_allow_in", 128'(MEM_allow_in), 128'(1'b1));
        step();
        chk("handover_flush_wb_valid", 128'(wb_valid), 128'(1'b0));

        // Cancel counter saturates, then drains one stale response per cycle
        for (int i = 0; i < 4; i++) begin
            issue(mk_exe(1'b0, 16'h0, 1'b1, 3'd0, 1'b1, 1'b1, 5'd5, 32'h0, 32'h1c00_4000));
            flush = 1'b1;
            step();
            flush = 1'b0;
        end
        chk("cancel_saturate", 128'(dut.cancel_cnt), 128'(3));
        data_sram_data_ok = 1'b1;
        for (int i = 0; i < 3; i++) step();
        data_sram_data_ok = 1'b0;
        chk("cancel_drained", 128'(dut.cancel_cnt), 128'(0));

        // Reset mid-load clears the stale-response count
        issue(mk_exe(1'b0, 16'h0, 1'b1, 3'd0, 1'b1, 1'b1, 5'd6, 32'h0, 32'h1c00_5000));
        flush = 1'b1;
        step();
        flush = 1'b0;
        issue(mk_exe(1'b0, 16'h0, 1'b1, 3'd0, 1'b1, 1'b1, 5'd6, 32'h4, 32'h1c00_5004));
        chk("pre_reset_cancel_cnt", 128'(dut.cancel_cnt), 128'(1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("midload_reset_cancel_cnt", 128'(dut.cancel_cnt), 128'(0));
        chk("midload_reset_bypass", 128'(MEM_bypass_bus), 128'(0));
        chk("midload_reset_allow_in", 128'(MEM_allow_in), 128'(1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage CPU pipeline, between EXE and WB. It holds the MEM pipeline register, waits for the data-SRAM response of loads issued in EXE, and aligns and extends load data. It owns the MEM→WB register that drives the WB stage's `valid` and `MEMreg_bus`, and it discards stale SRAM responses after a pipeline flush.

## Interface

**Parameters**
- `CANCEL_W`, default 2: width of the stale-response counter.

**Ports**
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `exe_valid` in 1: EXE holds a valid instruction.
- `EXE_ready_go` in 1: EXE is ready to hand over.
- `EXEreg_bus` in 92: {ertn 1, ebus 16, mem_req 1, ld_op 3, res_from_mem 1, rf_we 1, rf_waddr 5, alu_result 32, pc 32}.
- `MEM_allow_in` out 1: MEM can accept from EXE.
- `MEM_ready_go` out 1: MEM's result is complete.
- `data_sram_data_ok` in 1: a load or store response is present this cycle.
- `data_sram_rdata` in 32: load data.
- `flush` in 1: from WB (`except | ertn_flush | refetch_flush`).
- `WB_allow_in` in 1: WB can accept.
- `wb_valid` out 1: registered; drives WB `valid`.
- `MEMreg_bus` out 87: registered; {ertn 1, ebus 16, final_result 32, rf_we 1, rf_waddr 5, pc 32}.
- `MEM_bypass_bus` out 40: {mem_valid 1, load_pending 1, rf_we 1, rf_waddr 5, fwd_data 32}.

## Operation

**Register capture**
- `mem_valid` and the MEM fields load when `exe_valid & EXE_ready_go & MEM_allow_in`.
- `MEM_allow_in = ~mem_valid | (MEM_ready_go & WB_allow_in)`.

**Load wait**
- `need_data = mem_valid & mem_req & ~got_data`.
- `MEM_ready_go = ~need_data | data_ok_live`, where `data_ok_live = data_sram_data_ok & (cancel_cnt == 0)`.
- If `data_ok_live` arrives while WB is not accepting, latch `rdata_buf` and set `got_data`.
- Clear `got_data` when MEM advances.

**Load data formatting**
- Byte offset is `alu_result[1:0]`.
- `ld_op` encodings: 0 = LD.W, 1 = LD.B, 2 = LD.BU, 3 = LD.H, 4 = LD.HU.
- B/BU select byte `[8*off+:8]`; H/HU select halfword `[16*off[1]+:16]`. Sign- or zero-extend to 32 bits.
- `final_result = res_from_mem ? formatted : alu_result`.
- Other `ld_op` values are treated as LD.W.

**Exceptions**
- `ebus` passes through unchanged.
- EXE never sets `mem_req` with a nonzero `ebus`, so an excepting instruction never waits.

**Flush**
- Clear `mem_valid`, `wb_valid` and `got_data` next cycle.
- If `need_data` is set and no `data_ok` arrives in the flush cycle, increment `cancel_cnt`.
- Each later `data_sram_data_ok` while `cancel_cnt > 0` decrements it and is ignored.
- Saturate `cancel_cnt` at `2^CANCEL_W - 1`.

**Bypass bus**
- `load_pending = res_from_mem & ~MEM_ready_go`, so ID stalls on a load-use hazard.
- `fwd_data = final_result`.

**MEM→WB register**
- When `WB_allow_in`: `wb_valid <= mem_valid & MEM_ready_go & ~flush` and load `MEMreg_bus` with the formatted fields.

## Timing

**Reset values:** `mem_valid`, `wb_valid`, `got_data`, `cancel_cnt`, `rdata_buf` and `MEMreg_bus` are all 0. Hence `MEM_allow_in = 1`, `MEM_ready_go = 1`, bypass bus = 0.

**Latency**
- A non-memory instruction spends 1 cycle in MEM and reaches WB the cycle after capture.
- A load reaches WB the cycle after `data_ok_live`; `data_ok` in the capture-following cycle gives minimum latency.

**Boundary conditions**
- `data_ok` in the same cycle as `flush`: the response belongs to the flushed instruction. Drop it and do not increment `cancel_cnt`.
- `flush` in the same cycle as EXE handover: the incoming instruction is dropped (`mem_valid <= 0`).
- Reset mid-load: `cancel_cnt` clears to 0. The SRAM interface is reset with the core, so no stale response follows.
- Stores wait for `data_ok` exactly like loads; `rf_we` is 0 for stores.

## Structure

- Shared package/`macro.vh` holds:
  - bus widths `EXEReg_BUS_LEN = 92` and `MEMReg_BUS_LEN = 87`;
  - `LD_*` encodings;
  - `EBUS_*` indices.
- One natural sub-module: `load_align` (combinational: `ld_op`, `off`, `rdata` → 32-bit result).
- The remainder is flat registers plus the cancel counter.

## Test plan

- **ALU op:** `pc = 0x1c000000`, `alu_result = 0x5`, `rf_we = 1`, `rf_waddr = 3` → next cycle `wb_valid = 1`, `final_result = 0x5`.
- **Load byte:** LD.B, `alu_result[1:0] = 2`, `rdata = 0x12_80_34_56`, `data_ok` 3 cycles late → `MEM_ready_go = 0` for 3 cycles, `load_pending = 1`, then `final_result = 0xFFFFFF80`. LD.BU with the same stimulus gives `0x00000080`.
- **Load halfword:** LD.HU, `off = 2`, `rdata = 0x8001_0000` → `0x00008001`. LD.H with the same stimulus gives `0xFFFF8001`.
- **Backpressure:** `data_ok` while `WB_allow_in = 0` → `rdata_buf` holds the data. Release WB → correct result, no second wait.
- **Flush with outstanding load:** flush while `need_data` → `cancel_cnt = 1`. The next `data_ok` (`rdata = 0xDEADBEEF`) is ignored. The following load's `data_ok` is accepted and `wb_valid` rises once.
- **Flush racing data_ok:** flush and `data_ok` in the same cycle → `cancel_cnt` stays 0, `wb_valid = 0` next cycle.
